// File: rtl/power_mux_scheduler.sv
// power_mux_scheduler: scans the voltage-sense mux, majority-samples the comparator per
// channel and drops the kill-switch on persistent faults. Optional build macro: POWER_MUX_SOFTSTART_EN.
module power_mux_scheduler #(
  parameter int NUM_CH        = 8,
  parameter int SETTLE_CYCLES = 500,
  parameter int SAMPLE_CYCLES = 64,
  parameter int FAULT_LIMIT   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       data_in,
  input  logic [7:0] ch_mask,
  input  logic       kill_req,
  input  logic       rearm,
  output logic [2:0] mux,
  output logic       power,
  output logic [7:0] ch_status,
  output logic [2:0] fault_ch,
  output logic       killed,
  output logic       scan_done
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int SMP_W = $clog2(SAMPLE_CYCLES + 1);
  localparam int FLT_W = $clog2(FAULT_LIMIT + 1);

  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES);
  localparam logic [SMP_W-1:0] SAMPLE_LAST = SMP_W'(SAMPLE_CYCLES - 1);
  localparam logic [SMP_W-1:0] HALF        = SMP_W'(SAMPLE_CYCLES / 2);
  localparam logic [FLT_W-1:0] LIMIT       = FLT_W'(FAULT_LIMIT);
  localparam logic [2:0]       LAST_CH     = 3'(NUM_CH - 1);
  localparam logic [7:0]       CH_VALID    = 8'((1 << NUM_CH) - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_UPDATE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic [SMP_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [SMP_W-1:0] ones_q, ones_d;
  logic [2:0]       mux_q, mux_d;
  logic [7:0]       status_q, status_d;
  logic [2:0]       fault_ch_q, fault_ch_d;
  logic             killed_q, killed_d;
  logic             done_q, done_d;
  logic [1:0]       sync_q;
  logic [FLT_W-1:0] flt_cnt_q [8];
  logic [FLT_W-1:0] flt_cnt_d [8];

  logic             cur_good, masked, fault_active, fault_hit;
  logic [FLT_W-1:0] flt_cur, flt_next;

`ifdef POWER_MUX_SOFTSTART_EN
  logic soft_q, soft_d;
  logic started_q, started_d;
  logic ok_q, ok_d;
  logic chan_ok;
`endif

  always_comb begin
    // NOTE: every _d starts from its _q, so no path through this block can infer a latch.
    state_d    = state_q;
    set_cnt_d  = set_cnt_q;
    smp_cnt_d  = smp_cnt_q;
    ones_d     = ones_q;
    mux_d      = mux_q;
    status_d   = status_q;
    fault_ch_d = fault_ch_q;
    killed_d   = killed_q;
    done_d     = 1'b0;
    flt_cnt_d  = flt_cnt_q;

    cur_good = (ones_q > HALF);
    masked   = ch_mask[mux_q];
    flt_cur  = flt_cnt_q[mux_q];
    if (masked && !cur_good) flt_next = (flt_cur == LIMIT) ? LIMIT : flt_cur + FLT_W'(1);
    else                     flt_next = '0;

`ifdef POWER_MUX_SOFTSTART_EN
    soft_d       = soft_q;
    started_d    = started_q;
    ok_d         = ok_q;
    chan_ok      = cur_good | ~masked;
    fault_active = !killed_q && !soft_q;
`else
    fault_active = !killed_q;
`endif
    fault_hit = fault_active && (flt_next == LIMIT);

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_SETTLE;
          set_cnt_d = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (set_cnt_q == '0) begin
          state_d   = ST_SAMPLE;
          ones_d    = '0;
          smp_cnt_d = '0;
        end else begin
          set_cnt_d = set_cnt_q - SET_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (sync_q[1]) ones_d = ones_q + SMP_W'(1);
        smp_cnt_d = smp_cnt_q + SMP_W'(1);
        if (smp_cnt_q == SAMPLE_LAST) state_d = ST_UPDATE;
      end
      default: begin  // ST_UPDATE
        status_d[mux_q] = cur_good;
        // Counters are frozen whenever power is already held off.
        if (fault_active) flt_cnt_d[mux_q] = flt_next;
        if (fault_hit) begin
          fault_ch_d = mux_q;
          killed_d   = 1'b1;
        end else if (mux_q == LAST_CH) begin
          mux_d  = 3'd0;
          done_d = 1'b1;
        end else begin
          mux_d = mux_q + 3'd1;
        end
`ifdef POWER_MUX_SOFTSTART_EN
        if (soft_q) begin
          started_d = started_q | (mux_q == 3'd0);
          ok_d      = ((mux_q == 3'd0) ? 1'b1 : ok_q) & chan_ok;
          if ((mux_q == LAST_CH) && (started_q || (mux_q == 3'd0)) && ok_d && !killed_q)
            soft_d = 1'b0;
        end
`endif
        state_d   = enable ? ST_SETTLE : ST_IDLE;
        set_cnt_d = SETTLE_LOAD;
      end
    endcase

    // Rearm restarts the current channel; a simultaneous kill_req overrides it.
    if (killed_q && rearm && !kill_req) begin
      killed_d = 1'b0;
      for (int i = 0; i < 8; i++) flt_cnt_d[i] = '0;
      state_d   = enable ? ST_SETTLE : ST_IDLE;
      set_cnt_d = SETTLE_LOAD;
`ifdef POWER_MUX_SOFTSTART_EN
      soft_d    = 1'b1;
      started_d = 1'b0;
      ok_d      = 1'b0;
`endif
    end

    if (kill_req) killed_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      set_cnt_q  <= '0;
      smp_cnt_q  <= '0;
      ones_q     <= '0;
      mux_q      <= '0;
      status_q   <= '0;
      fault_ch_q <= '0;
      killed_q   <= 1'b0;
      done_q     <= 1'b0;
      sync_q     <= '0;
      // NOTE: the fault counters are a small register array that must start cleared, so it is reset like any other state.
      for (int i = 0; i < 8; i++) flt_cnt_q[i] <= '0;
`ifdef POWER_MUX_SOFTSTART_EN
      soft_q     <= 1'b1;
      started_q  <= 1'b0;
      ok_q       <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q    <= state_d;
      set_cnt_q  <= set_cnt_d;
      smp_cnt_q  <= smp_cnt_d;
      ones_q     <= ones_d;
      mux_q      <= mux_d;
      status_q   <= status_d;
      fault_ch_q <= fault_ch_d;
      killed_q   <= killed_d;
      done_q     <= done_d;
      sync_q     <= {sync_q[0], data_in};
      flt_cnt_q  <= flt_cnt_d;
`ifdef POWER_MUX_SOFTSTART_EN
      soft_q     <= soft_d;
      started_q  <= started_d;
      ok_q       <= ok_d;
`endif
    end
  end

  assign mux       = mux_q;
  assign ch_status = status_q & CH_VALID;
  assign fault_ch  = fault_ch_q;
  assign killed    = killed_q;
  assign scan_done = done_q;
`ifdef POWER_MUX_SOFTSTART_EN
  assign power     = ~killed_q & ~soft_q;
`else
  assign power     = ~killed_q;
`endif

endmodule

// File: tb/tb_power_mux_scheduler.sv
// Directed bench for power_mux_scheduler with NUM_CH=8, SETTLE=4, SAMPLE=8, FAULT_LIMIT=3;
// one channel takes 14 clocks, so channel g of the run completes its UPDATE at edge 1+14*(g+1).
module tb_power_mux_scheduler;

`ifdef POWER_MUX_SOFTSTART_EN
  localparam logic RST_POWER = 1'b0;
`else
  localparam logic RST_POWER = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       data_in = 1'b1;
  logic [7:0] ch_mask = 8'hFF;
  logic       kill_req = 1'b0;
  logic       rearm = 1'b0;
  logic [2:0] mux;
  logic       power;
  logic [7:0] ch_status;
  logic [2:0] fault_ch;
  logic       killed;
  logic       scan_done;

  int n_cmp = 0;
  int n_bad = 0;

  power_mux_scheduler #(
    .NUM_CH(8), .SETTLE_CYCLES(4), .SAMPLE_CYCLES(8), .FAULT_LIMIT(3)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .data_in(data_in), .ch_mask(ch_mask),
    .kill_req(kill_req), .rearm(rearm), .mux(mux), .power(power), .ch_status(ch_status),
    .fault_ch(fault_ch), .killed(killed), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_mux(input logic [2:0] ch, input int budget);
    int n = 0;
    while (mux !== ch && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (mux !== ch) check("wait_mux_timeout", {29'd0, mux}, {29'd0, ch});
  endtask

  // Counts cycles and scan_done pulses from now until killed rises; optionally makes
  // scan 2 read good by driving data_in high between the first and second wrap.
  task automatic run_to_kill(input int budget, input bit good_scan2, output int cyc, output int dones);
    cyc = 0;
    dones = 0;
    while (killed !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (scan_done === 1'b1) begin
        dones++;
        if (good_scan2) data_in = (dones == 1);
      end
    end
    if (killed !== 1'b1) check("kill_timeout", {31'd0, killed}, 32'd1);
  endtask

  initial begin
    int cyc, dones, n;
    logic [2:0] nxt;

    // Reset values while reset is held
    @(negedge clk);
    check("rst_mux", {29'd0, mux}, 32'd0);
    check("rst_power", {31'd0, power}, {31'd0, RST_POWER});
    check("rst_status", {24'd0, ch_status}, 32'd0);
    check("rst_fault_ch", {29'd0, fault_ch}, 32'd0);
    check("rst_killed", {31'd0, killed}, 32'd0);
    check("rst_scan_done", {31'd0, scan_done}, 32'd0);
    reset = 1'b0;

    // Single pass, all good: mux steps every 14 clocks, wraps with scan_done
    wait_mux(3'd1, 40);
    for (int k = 1; k <= 7; k++) begin
      nxt = (k == 7) ? 3'd0 : 3'(k + 1);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (mux !== nxt && n < 40);
      check($sformatf("mux_step_%0d", k), n, 32'd14);
    end
    check("wrap_scan_done", {31'd0, scan_done}, 32'd1);
    check("pass_status", {24'd0, ch_status}, 32'hFF);
    check("pass_power", {31'd0, power}, {31'd0, RST_POWER});
    check("pass_killed", {31'd0, killed}, 32'd0);

    // Majority threshold on channel 2: 4 of 8 high is bad, 5 of 8 high is good
    ch_mask = 8'h00;
    data_in = 1'b0;
    for (int p = 4; p <= 5; p++) begin
      wait_mux(3'd2, 200);
      repeat (6) @(posedge clk);
      @(negedge clk);
      data_in = 1'b1;
      repeat (p) @(negedge clk);
      data_in = 1'b0;
      wait_mux(3'd3, 40);
      check($sformatf("majority_%0d", p), {24'd0, ch_status}, (p == 4) ? 32'hF8 : 32'h04);
    end

    // Unmasked channels reading bad never kill
    repeat (350) @(negedge clk);
    check("unmasked_status", {24'd0, ch_status}, 32'h00);
    check("unmasked_power", {31'd0, power}, {31'd0, RST_POWER});
    check("unmasked_killed", {31'd0, killed}, 32'd0);

    // Channel 2 masked and bad every scan: kill at the scan-3 UPDATE of channel 2 (g=18)
    ch_mask = 8'h04;
    do_reset();
    run_to_kill(900, 1'b0, cyc, dones);
    check("fault_kill_cycle", cyc, 32'd267);
    check("fault_scans_before", dones, 32'd2);
    check("fault_power", {31'd0, power}, 32'd0);
    check("fault_ch", {29'd0, fault_ch}, 32'd2);
    check("fault_mux_held", {29'd0, mux}, 32'd2);

    // Rearm alone restores power one cycle later
    ch_mask = 8'h00;
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    check("rearm_power", {31'd0, power}, 32'd1);
    check("rearm_killed", {31'd0, killed}, 32'd0);

    // Software kill during SAMPLE; fault_ch keeps the last automatic value
    repeat (7) @(negedge clk);
    kill_req = 1'b1;
    @(negedge clk);
    kill_req = 1'b0;
    check("swkill_power", {31'd0, power}, 32'd0);
    check("swkill_killed", {31'd0, killed}, 32'd1);
    check("swkill_fault_ch", {29'd0, fault_ch}, 32'd2);

    kill_req = 1'b1;
    rearm = 1'b1;
    @(negedge clk);
    kill_req = 1'b0;
    rearm = 1'b0;
    check("both_killed", {31'd0, killed}, 32'd1);
    check("both_power", {31'd0, power}, 32'd0);

    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    check("rearm2_power", {31'd0, power}, 32'd1);
    check("rearm2_killed", {31'd0, killed}, 32'd0);

    // A good reading in scan 2 clears the count: kill moves to scan 5 (g=34)
    ch_mask = 8'h04;
    data_in = 1'b0;
    do_reset();
    run_to_kill(900, 1'b1, cyc, dones);
    check("recover_kill_cycle", cyc, 32'd491);
    check("recover_scans_before", dones, 32'd4);
    check("recover_fault_ch", {29'd0, fault_ch}, 32'd2);
    check("recover_power", {31'd0, power}, 32'd0);

    // Scanning continues while killed; async reset mid-SETTLE on channel 5
    ch_mask = 8'h00;
    data_in = 1'b1;
    wait_mux(3'd5, 200);
    @(negedge clk);
    check("pre_reset_status", {24'd0, ch_status}, 32'h1C);
    check("pre_reset_killed", {31'd0, killed}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_mux", {29'd0, mux}, 32'd0);
    check("async_status", {24'd0, ch_status}, 32'd0);
    check("async_power", {31'd0, power}, {31'd0, RST_POWER});
    check("async_killed", {31'd0, killed}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/power_mux_scheduler.md
Name: power_mux_scheduler

Overview:
- Sequences the 3-bit battery/rail voltage-sense mux and samples the 1-bit comparator data line once per channel.
- Builds a per-channel good/bad status vector.
- Drives the kill-switch `power` output low when any monitored channel stays bad for FAULT_LIMIT consecutive scans, or when software requests a kill.
- Sits between the power-management Avalon slave registers and the GPIO_1 sense pins, on the 50 MHz system clock.

Parameters:
- NUM_CH, 8, number of mux channels scanned (1..8); channels 0..NUM_CH-1.
- SETTLE_CYCLES, 500, clocks to wait after changing `mux` before sampling (>=1).
- SAMPLE_CYCLES, 64, clocks over which `data_in` is sampled per channel (>=1).
- FAULT_LIMIT, 3, consecutive bad scans on a masked channel before kill (>=1).

Ports:
- clk, input, 1, system clock (CLOCK_50 domain).
- reset, input, 1, asynchronous active-high reset.
- enable, input, 1, scanning runs while 1; when 0, the FSM finishes the current channel and then idles.
- data_in, input, 1, comparator output from the sense board; asynchronous; 1 = voltage above threshold.
- ch_mask, input, 8, channel n participates in fault detection when ch_mask[n]=1.
- kill_req, input, 1, one-cycle software kill request.
- rearm, input, 1, one-cycle request to leave KILLED.
- mux, output, 3, selected sense channel.
- power, output, 1, kill-switch drive; 1 = motors powered.
- ch_status, output, 8, last sampled status per channel (1 = good); bits >= NUM_CH read 0.
- fault_ch, output, 3, channel that caused the most recent automatic kill.
- killed, output, 1, 1 while in KILLED.
- scan_done, output, 1, one-cycle pulse after channel NUM_CH-1 is updated.

Behaviour:
- Reset values:
  - mux=0, power=1 (see the optional feature), ch_status=0, fault_ch=0, killed=0, scan_done=0.
  - All fault counters = 0; FSM in IDLE.
- `data_in` passes through a 2-flop synchronizer; all sampling uses the synchronized value, giving 2 cycles of input latency.
- IDLE: if enable=1, load the settle counter and go to SETTLE, keeping mux at its current value.
- SETTLE: count SETTLE_CYCLES clocks, then clear the ones-counter and go to SAMPLE.
- SAMPLE:
  - For SAMPLE_CYCLES clocks, increment the ones-counter when the synchronized input is 1.
  - Counter width is clog2(SAMPLE_CYCLES+1); it never wraps.
  - Then go to UPDATE.
- UPDATE (one cycle):
  - Status bit = 1 if ones > SAMPLE_CYCLES/2 (integer division); write ch_status[mux].
  - If ch_mask[mux]=1 and status=0: increment fault_cnt[mux], saturating at FAULT_LIMIT. Otherwise clear fault_cnt[mux].
  - If fault_cnt[mux] reaches FAULT_LIMIT this cycle: set fault_ch=mux and go to KILLED.
  - Otherwise advance mux, wrapping NUM_CH-1 -> 0. On the wrap, pulse scan_done the next cycle.
  - Next state is SETTLE if enable=1, else IDLE.
- KILLED:
  - power=0 and killed=1; scanning continues so ch_status stays live, but fault counters are frozen.
  - On rearm: clear all fault counters and return to SETTLE (enable=1) or IDLE.
  - power returns to 1 on the cycle after rearm.
- kill_req in any state forces KILLED on the next cycle; fault_ch is unchanged for software kills.
- kill_req and rearm asserted in the same cycle: kill_req wins.
- rearm outside KILLED is ignored.
- A change of ch_mask takes effect at the next UPDATE. Clearing a mask bit clears that channel's counter at its next UPDATE.
- Reset asserted mid-scan returns everything to reset values immediately, asynchronously.

Optional Feature:
- Macro POWER_MUX_SOFTSTART_EN.
- Defined:
  - power resets to 0, and the FSM enters KILLED with killed=0 and a soft-start flag set.
  - power goes to 1 only after one complete scan in which every masked channel reads good; then the flag clears.
  - rearm from KILLED also re-enters soft-start instead of enabling power immediately.
- Undefined: power resets to 1 and rearm restores power directly, as above.

Test Plan:
- Single pass, NUM_CH=8, SETTLE=4, SAMPLE=8, data_in held 1, enable=1: mux steps 0..7 every 14 clocks (4 settle + 8 sample + 1 update + 1 re-entry); ch_status=8'hFF; scan_done pulses once per 8 channels; power stays 1.
- Majority threshold, SAMPLE=8, data_in high for exactly 4 of the 8 samples on channel 2: ch_status[2]=0. Exactly 5 high: ch_status[2]=1.
- Fault, ch_mask=8'h04, channel 2 low in every scan, FAULT_LIMIT=3: power drops to 0 in the UPDATE cycle of scan 3; fault_ch=2; killed=1. A good reading in scan 2 instead resets the count, so no kill occurs until 3 further bad scans.
- Unmasked fault, ch_mask=8'h00, all channels low: ch_status=0 and power stays 1 indefinitely.
- Software kill, kill_req pulsed during SAMPLE: power=0 next cycle; fault_ch unchanged. Then kill_req and rearm together: stays killed. rearm alone: power=1 one cycle later.
- Async reset asserted mid-SETTLE on channel 5: mux=0, ch_status=0, power=1 immediately, without waiting for a clock edge. With POWER_MUX_SOFTSTART_EN: power=0 until the first all-good scan completes.
